// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. One shared BCD-to-7-segment decoder is fed one nibble at a time
//   while the matching active-low digit select is pulled low. New display data
//   is accepted through a single-entry load/ack handshake and is only applied
//   at frame boundaries, so a frame never mixes old and new digits.
//
// Parameters
//   DIV  clocks each digit is lit per slot (>= 1)
//   GAP  dead-time clocks with all digits dark after each slot (0 = no gap)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   en       scan enable; 0 = display dark, scan halted
//   load     one-cycle strobe requesting display of din
//   din      four BCD digits, din[3:0] is digit 0 (rightmost)
//   ack      one-cycle pulse: requested data is now on the display
//   pending  a load has been accepted but not applied yet
//   bcd      nibble for the shared decoder
//   dec_en   decoder enable
//   dig_n    active-low digit selects, dig_n[i] lights digit i
//   frame    one-cycle pulse in the last cycle of the digit-3 slot
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits 3..1 are dark while they and
//                          every higher digit are zero (digit 0 always shows).

module seg_scan_ctrl #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  output logic        ack,
  output logic        pending,
  output logic [3:0]  bcd,
  output logic        dec_en,
  output logic [3:0]  dig_n,
  output logic        frame
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   shadow;
  logic [15:0]   pend_data;
  logic          slot_end;
  logic          apply;
  logic [3:0]    nibble;
  logic          zero_blank;
  logic          blank;

  // A slot ends on the last gap cycle, or on the last lit cycle when there
  // is no gap at all. The end of the digit-3 slot is the frame boundary.
  assign slot_end = ((state == ST_GAP) && (cnt == GAP_LAST)) ||
                    (!HAS_GAP && (state == ST_SHOW) && (cnt == DIV_LAST));
  assign frame    = slot_end && (idx == 2'd3);

  // Data may be swapped in at a frame boundary, or at any clock while the
  // scan is idle since nothing is being shown then.
  assign apply = frame || (state == ST_IDLE);

  // Scan sequencing: IDLE -> SHOW(0) -> [GAP] -> SHOW(1) ... Dropping en
  // returns to IDLE from anywhere and restarts at digit 0.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    if (!en) begin
      state_nx = ST_IDLE;
      idx_nx   = 2'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_SHOW;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
        end
        ST_SHOW: begin
          if (cnt == DIV_LAST) begin
            cnt_nx = '0;
            if (HAS_GAP) begin
              state_nx = ST_GAP;
            end else begin
              idx_nx = idx + 2'd1;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_nx   = '0;
            state_nx = ST_SHOW;
            idx_nx   = idx + 2'd1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          idx_nx   = 2'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Display outputs come only from registered state and the shadow copy, so
  // din/load never reach bcd or dig_n combinationally. A blanked digit must
  // keep its anode off: the decoder lights every segment when disabled or
  // fed a non-BCD nibble.
  always_comb begin
    case (idx)
      2'd0:    nibble = shadow[3:0];
      2'd1:    nibble = shadow[7:4];
      2'd2:    nibble = shadow[11:8];
      default: nibble = shadow[15:12];
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd1:    zero_blank = (shadow[15:4] == 12'h000);
      2'd2:    zero_blank = (shadow[15:8] == 8'h00);
      2'd3:    zero_blank = (shadow[15:12] == 4'h0);
      default: zero_blank = 1'b0;
    endcase
`else
    zero_blank = 1'b0;
`endif

    blank  = (nibble > 4'd9) || zero_blank;
    bcd    = 4'd0;
    dec_en = 1'b0;
    dig_n  = 4'b1111;
    if (state == ST_SHOW) begin
      bcd = nibble;
      if (!blank) begin
        dec_en = 1'b1;
        dig_n  = ~(4'b0001 << idx);
      end
    end
  end

  // Single-entry load buffer. A load in the apply cycle itself wins over the
  // buffered value; repeated loads before a boundary just overwrite the
  // buffer, so they produce a single ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= 16'h0000;
      pend_data <= 16'h0000;
      pending   <= 1'b0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (apply && (pending || load)) begin
        shadow  <= load ? din : pend_data;
        pending <= 1'b0;
        ack     <= 1'b1;
      end else if (load) begin
        pend_data <= din;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with DIV=4, GAP=1. A behavioural
//   model tracks time since scan start and derives the lit digit from it;
//   a compare process checks every cycle against that model, and directed
//   scenarios pin hand-computed values.
//   Honours LEADING_ZERO_BLANK_EN when defined.

module tb_seg_scan_ctrl;

  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int PERIOD = DIV + GAP;
  localparam int FRAME  = 4 * PERIOD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic        ack;
  logic        pending;
  logic [3:0]  bcd;
  logic        dec_en;
  logic [3:0]  dig_n;
  logic        frame;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .din    (din),
    .ack    (ack),
    .pending(pending),
    .bcd    (bcd),
    .dec_en (dec_en),
    .dig_n  (dig_n),
    .frame  (frame)
  );

  // Behavioural model: m_t counts clocks since the scan started.
  bit          m_active    = 1'b0;
  int          m_t         = 0;
  logic [15:0] m_shadow    = 16'h0000;
  logic [15:0] m_pend_data = 16'h0000;
  bit          m_pending   = 1'b0;
  bit          m_ack       = 1'b0;

  function automatic bit m_frame();
    return m_active && (m_t == FRAME - 1);
  endfunction

  always @(posedge clk) begin : model_step
    bit boundary;
    bit idle;
    boundary = m_frame();
    idle     = !m_active;
    if (!rst_n) begin
      m_active    = 1'b0;
      m_t         = 0;
      m_shadow    = 16'h0000;
      m_pend_data = 16'h0000;
      m_pending   = 1'b0;
      m_ack       = 1'b0;
    end else begin
      m_ack = 1'b0;
      if ((boundary || idle) && (m_pending || load)) begin
        m_shadow  = load ? din : m_pend_data;
        m_pending = 1'b0;
        m_ack     = 1'b1;
      end else if (load) begin
        m_pend_data = din;
        m_pending   = 1'b1;
      end
      if (!en) begin
        m_active = 1'b0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit l, input logic [15:0] d);
    en   = e;
    load = l;
    din  = d;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    int          d;
    int          phase;
    logic [3:0]  nib;
    bit          show;
    logic [3:0]  e_dig;
    bit          e_dec;
    if (cmp_en) begin
      e_dig = 4'b1111;
      e_dec = 1'b0;
      nib   = 4'd0;
      show  = 1'b0;
      if (m_active) begin
        d     = (m_t / PERIOD) % 4;
        phase = m_t % PERIOD;
        nib   = 4'(m_shadow >> (4 * d));
        show  = (phase < DIV) && (nib <= 4'd9) &&
                !(LZB && (d > 0) && ((m_shadow >> (4 * d)) == 16'h0000));
        if (show) begin
          e_dig = ~(4'b0001 << d);
          e_dec = 1'b1;
        end
      end
      checkOutput("m_dig_n", 16'(dig_n), 16'(e_dig));
      checkOutput("m_dec_en", 16'(dec_en), 16'(e_dec));
      checkOutput("m_frame", 16'(frame), 16'(m_frame()));
      checkOutput("m_ack", 16'(ack), 16'(m_ack));
      checkOutput("m_pending", 16'(pending), 16'(m_pending));
      if (show) checkOutput("m_bcd", 16'(bcd), 16'(nib));
      if (!m_active) checkOutput("m_bcd_idle", 16'(bcd), 16'h0000);
    end
  end

  task automatic waitAck(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    checkOutput("ack_seen", 16'(seen), 16'h0001);
  endtask

  task automatic waitModelT(input int target, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (m_active && (m_t == target)) hit = 1'b1;
    end
    checkOutput("pos_reached", 16'(hit), 16'h0001);
  endtask

  // Called on the ack cycle (digit 0, first lit cycle); checks the first
  // lit cycle of each digit against hand-derived selects and nibbles.
  task automatic checkDigits(input logic [15:0] edig, input logic [15:0] ebcd);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (PERIOD) @(negedge clk);
      checkOutput("digit_sel", 16'(dig_n), 16'(edig[4*d +: 4]));
      checkOutput("digit_dec_en", 16'(dec_en), 16'(edig[4*d +: 4] != 4'hF));
      if (edig[4*d +: 4] != 4'hF) checkOutput("digit_bcd", 16'(bcd), 16'(ebcd[4*d +: 4]));
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_dig_n", 16'(dig_n), 16'h000F);
    checkOutput("rst_dec_en", 16'(dec_en), 16'h0000);
    checkOutput("rst_bcd", 16'(bcd), 16'h0000);
    checkOutput("rst_ack", 16'(ack), 16'h0000);
    checkOutput("rst_pending", 16'(pending), 16'h0000);
    checkOutput("rst_frame", 16'(frame), 16'h0000);
  endtask

  function automatic logic [15:0] rand_din();
    logic [15:0] v;
    int          k;
    v = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9 && $urandom_range(0, 2) != 0) v[4*i +: 4] = v[4*i +: 4] - 4'd6;
    end
    k = $urandom_range(0, 4);
    if (k > 0) v = v & (16'hFFFF >> (4 * k));
    return v;
  endfunction

  logic [3:0] scan_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin : stimulus
    int         slot;
    logic [3:0] exp_dig;
    int         ack_count;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    checkResetOutputs();

    // Plain scan of zeros: 4 lit / 1 dark per digit, frame every 20 clocks.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      slot    = (k / PERIOD) % 4;
      exp_dig = ((k % PERIOD) == PERIOD - 1 || (LZB && slot != 0)) ? 4'b1111 : scan_pat[slot];
      checkOutput("scan_dig_n", 16'(dig_n), 16'(exp_dig));
      checkOutput("scan_frame", 16'(frame), 16'(k == 19 || k == 39));
      if (exp_dig != 4'b1111) checkOutput("scan_bcd", 16'(bcd), 16'h0000);
    end

    // Single load mid-frame.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("load_pending", 16'(pending), 16'h0001);
    waitAck(FRAME + 5);
    checkOutput("ack_pending_clr", 16'(pending), 16'h0000);
    checkDigits(16'h7BDE, 16'h1234);

    // Two loads before one boundary: last one wins, one ack.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h1111);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h5678);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("dbl_pending", 16'(pending), 16'h0001);
    waitAck(FRAME + 5);
    checkDigits(16'h7BDE, 16'h5678);
    ack_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ack) ack_count++;
    end
    checkOutput("dbl_extra_ack", 16'(ack_count), 16'h0000);

    // Invalid digit and leading zeros.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h00A7);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    waitAck(FRAME + 5);
    checkDigits(LZB ? 16'hFFFE : 16'h7BFE, 16'h0007);

    // Drop en in the middle of the digit-2 slot, then restart.
    waitModelT(2 * PERIOD + 1, 2 * FRAME);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("en_off_dig_n", 16'(dig_n), 16'h000F);
    checkOutput("en_off_dec_en", 16'(dec_en), 16'h0000);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("restart_dig_n", 16'(dig_n), 16'h000E);
    checkOutput("restart_bcd", 16'(bcd), 16'h0007);

    // Load while idle is applied on the next clock.
    applyStimulus(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h4321);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("idle_ack", 16'(ack), 16'h0001);
    checkOutput("idle_pending", 16'(pending), 16'h0000);
    @(negedge clk);
    checkOutput("idle_dig_n", 16'(dig_n), 16'h000E);
    checkOutput("idle_bcd", 16'(bcd), 16'h0001);

    // Load in the boundary cycle beats the buffered value.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h1111);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    waitModelT(FRAME - 1, 2 * FRAME);
    applyStimulus(1'b1, 1'b1, 16'h9876);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("bnd_ack", 16'(ack), 16'h0001);
    checkOutput("bnd_bcd", 16'(bcd), 16'h0006);
    checkOutput("bnd_dig_n", 16'(dig_n), 16'h000E);

    // Reset with a load pending discards it.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h2468);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("pre_rst_pending", 16'(pending), 16'h0001);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_dig_n", 16'(dig_n), 16'h000E);
    checkOutput("post_rst_bcd", 16'(bcd), 16'h0000);
    ack_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (ack) ack_count++;
    end
    checkOutput("post_rst_no_ack", 16'(ack_count), 16'h0000);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 9) == 0, rand_din());
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
